sram_bus_arbiter: RTL and testbench

SRAM_BUS_ARBITER -- requirements
Module: sram_bus_arbiter

---
 rtl/sram_bus_arbiter_pkg.sv | 42 ++++
 rtl/sram_bus_arbiter.sv | 130 +++++++++++++
 tb/tb_sram_bus_arbiter.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter_pkg
//  Description : Shared encodings and command record for the SRAM bus arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_bus_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_ADDR = 2'd1;
   localparam logic [1:0] ST_DATA = 2'd2;

   localparam logic OWNER_INST = 1'b0;
   localparam logic OWNER_DATA = 1'b1;

   // Everything the bus needs to replay a request after it has been granted.
   typedef struct packed {
      logic        wr;
      logic [1:0]  size;
      logic [3:0]  wstrb;
      logic [31:0] addr;
      logic [31:0] wdata;
   } bus_cmd_t;

   function automatic bus_cmd_t pack_cmd(
      input logic        wr,
      input logic [1:0]  size,
      input logic [3:0]  wstrb,
      input logic [31:0] addr,
      input logic [31:0] wdata
   );
      bus_cmd_t cmd;
      cmd.wr    = wr;
      cmd.size  = size;
      cmd.wstrb = wstrb;
      cmd.addr  = addr;
      cmd.wdata = wdata;
      return cmd;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_bus_arbiter
//  Description : Two-master (inst/data) to one SRAM-like bus arbiter, one
//                transaction outstanding, data side has fixed priority.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_bus_arbiter
   import sram_bus_arbiter_pkg::*;
(
   input  logic        clk,
   input  logic        reset,

   input  logic        inst_req,
   input  logic        inst_wr,
   input  logic [1:0]  inst_size,
   input  logic [3:0]  inst_wstrb,
   input  logic [31:0] inst_addr,
   input  logic [31:0] inst_wdata,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,

   input  logic        data_req,
   input  logic        data_wr,
   input  logic [1:0]  data_size,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,

   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [3:0]  bus_wstrb,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,

   input  logic        flush,
   output logic        busy
);

   logic [1:0] r_state;
   logic [1:0] w_state_nxt;
   logic       r_owner;
   logic       r_cancel;
   bus_cmd_t   r_cmd;

   logic       w_grant;
   logic       w_grant_owner;
   bus_cmd_t   w_grant_cmd;
   logic       w_in_idle;
   logic       w_in_addr;
   logic       w_in_data;
   logic       w_inst_owner;
   logic       w_data_owner;
   logic       w_inst_dropped;

   assign w_in_idle    = (r_state == ST_IDLE);
   assign w_in_addr    = (r_state == ST_ADDR);
   assign w_in_data    = (r_state == ST_DATA);
   assign w_inst_owner = (r_owner == OWNER_INST);
   assign w_data_owner = (r_owner == OWNER_DATA);

   // Data side always wins a simultaneous request.
   assign w_grant       = data_req | inst_req;
   assign w_grant_owner = data_req ? OWNER_DATA : OWNER_INST;
   assign w_grant_cmd   = data_req
                        ? pack_cmd(data_wr, data_size, data_wstrb, data_addr, data_wdata)
                        : pack_cmd(inst_wr, inst_size, inst_wstrb, inst_addr, inst_wdata);

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_grant)     w_state_nxt = ST_ADDR;
         ST_ADDR: if (bus_addr_ok) w_state_nxt = ST_DATA;
         ST_DATA: if (bus_data_ok) w_state_nxt = ST_IDLE;
         default:                  w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= ST_IDLE;
         r_owner  <= OWNER_INST;
         r_cancel <= 1'b0;
         r_cmd    <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_in_idle && w_grant) begin
            r_owner <= w_grant_owner;
            r_cmd   <= w_grant_cmd;
         end
         // A flushed fetch still runs to completion on the bus; only its
         // response to the instruction side is swallowed.
         if (w_state_nxt == ST_IDLE) begin
            r_cancel <= 1'b0;
         end else if (flush && !w_in_idle && w_inst_owner) begin
            r_cancel <= 1'b1;
         end
      end
   end

   // A flush arriving in the completing cycle itself must also drop the data.
   assign w_inst_dropped = r_cancel | flush;

   assign inst_addr_ok = w_in_addr & w_inst_owner & bus_addr_ok;
   assign data_addr_ok = w_in_addr & w_data_owner & bus_addr_ok;
   assign inst_data_ok = w_in_data & w_inst_owner & bus_data_ok & ~w_inst_dropped;
   assign data_data_ok = w_in_data & w_data_owner & bus_data_ok;

   assign inst_rdata = bus_rdata;
   assign data_rdata = bus_rdata;

   assign bus_req   = w_in_addr;
   assign bus_wr    = w_in_addr ? r_cmd.wr    : 1'b0;
   assign bus_size  = w_in_addr ? r_cmd.size  : 2'd0;
   assign bus_wstrb = w_in_addr ? r_cmd.wstrb : 4'd0;
   assign bus_addr  = w_in_addr ? r_cmd.addr  : 32'd0;
   assign bus_wdata = w_in_addr ? r_cmd.wdata : 32'd0;

   assign busy = ~w_in_idle;

endmodule
`default_nettype wire

// File: tb/tb_sram_bus_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_bus_arbiter
//  Description : Directed self-checking bench for sram_bus_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sram_bus_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        inst_req = 1'b0, inst_wr = 1'b0;
   logic [1:0]  inst_size = 2'd0;
   logic [3:0]  inst_wstrb = 4'd0;
   logic [31:0] inst_addr = 32'd0, inst_wdata = 32'd0;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req = 1'b0, data_wr = 1'b0;
   logic [1:0]  data_size = 2'd0;
   logic [3:0]  data_wstrb = 4'd0;
   logic [31:0] data_addr = 32'd0, data_wdata = 32'd0;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        bus_req, bus_wr;
   logic [1:0]  bus_size;
   logic [3:0]  bus_wstrb;
   logic [31:0] bus_addr, bus_wdata;
   logic        bus_addr_ok = 1'b0, bus_data_ok = 1'b0;
   logic [31:0] bus_rdata = 32'd0;
   logic        flush = 1'b0;
   logic        busy;

   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   sram_bus_arbiter dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_wstrb(inst_wstrb), .inst_addr(inst_addr), .inst_wdata(inst_wdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
      .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_addr_ok(bus_addr_ok), .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata),
      .flush(flush), .busy(busy)
   );

   // Status vector order: inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, busy
   wire [5:0] st = {inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok, bus_req, busy};

   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      inst_req = 1'b0; inst_wr = 1'b0; inst_size = 2'd0; inst_wstrb = 4'd0;
      inst_addr = 32'd0; inst_wdata = 32'd0;
      data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'd0;
      data_addr = 32'd0; data_wdata = 32'd0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0; flush = 1'b0;
   endtask

   task automatic test_reset();
      inst_req = 1'b1; data_req = 1'b1; data_addr = 32'hDEAD0000; bus_addr_ok = 1'b1;
      cyc(); #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL reset_status got=%b want=000000", st);
      end
      total++;
      if ({bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata} !== 71'd0) begin
         bad++; $display("FAIL reset_bus_fields got addr=%h wdata=%h", bus_addr, bus_wdata);
      end
      clear_inputs();
      reset = 1'b0;
      cyc(); #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL post_reset_idle got=%b want=000000", st);
      end
   endtask

   task automatic test_inst_read();
      cyc(); inst_req = 1'b1; inst_size = 2'd2; inst_addr = 32'h1C000000; #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL inst_read_c1 got=%b want=000000", st);
      end
      cyc(); inst_req = 1'b0; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b100011 || bus_addr !== 32'h1C000000 || bus_wr !== 1'b0 || bus_size !== 2'd2) begin
         bad++; $display("FAIL inst_read_c2 got=%b addr=%h want=100011 addr=1c000000", st, bus_addr);
      end
      cyc(); bus_addr_ok = 1'b0; #1;
      total++;
      if (st !== 6'b000001) begin
         bad++; $display("FAIL inst_read_c3 got=%b want=000001", st);
      end
      cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h02800C0C; #1;
      total++;
      if (st !== 6'b010001 || inst_rdata !== 32'h02800C0C || data_rdata !== 32'h02800C0C) begin
         bad++; $display("FAIL inst_read_c4 got=%b rdata=%h want=010001 rdata=02800c0c", st, inst_rdata);
      end
      cyc(); bus_data_ok = 1'b0; #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL inst_read_done got=%b want=000000", st);
      end
   endtask

   task automatic test_priority();
      cyc();
      inst_req = 1'b1; inst_addr = 32'h1C000010; inst_size = 2'd2;
      data_req = 1'b1; data_wr = 1'b1; data_size = 2'd1; data_wstrb = 4'b0011;
      data_addr = 32'h00000104; data_wdata = 32'h0000BEEF;
      cyc(); data_req = 1'b0; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b001011) begin
         bad++; $display("FAIL prio_owner got=%b want=001011", st);
      end
      total++;
      if (bus_wr !== 1'b1 || bus_size !== 2'd1 || bus_wstrb !== 4'b0011 ||
          bus_addr !== 32'h00000104 || bus_wdata !== 32'h0000BEEF) begin
         bad++; $display("FAIL prio_store_fields got wr=%b sz=%0d strb=%b addr=%h wdata=%h want 1/1/0011/00000104/0000beef",
                         bus_wr, bus_size, bus_wstrb, bus_addr, bus_wdata);
      end
      cyc(); bus_addr_ok = 1'b0;
      cyc(); bus_data_ok = 1'b1; #1;
      total++;
      if (st !== 6'b000101) begin
         bad++; $display("FAIL prio_store_done got=%b want=000101", st);
      end
      cyc(); bus_data_ok = 1'b0; #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL prio_gap_idle got=%b want=000000", st);
      end
      cyc(); inst_req = 1'b0; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b100011 || bus_addr !== 32'h1C000010 || bus_wr !== 1'b0) begin
         bad++; $display("FAIL prio_inst_grant got=%b addr=%h want=100011 addr=1c000010", st, bus_addr);
      end
      cyc(); bus_addr_ok = 1'b0;
      cyc(); bus_data_ok = 1'b1; bus_rdata = 32'h11112222; #1;
      total++;
      if (st !== 6'b010001) begin
         bad++; $display("FAIL prio_inst_done got=%b want=010001", st);
      end
      cyc(); clear_inputs();
   endtask

   task automatic test_flush_idle();
      cyc(); inst_req = 1'b1; flush = 1'b1; inst_addr = 32'h1C000020;
      cyc(); inst_req = 1'b0; flush = 1'b0; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b100011 || bus_addr !== 32'h1C000020) begin
         bad++; $display("FAIL flush_idle_grant got=%b addr=%h want=100011", st, bus_addr);
      end
      cyc(); bus_addr_ok = 1'b0;
      cyc(); bus_data_ok = 1'b1; #1;
      total++;
      if (st !== 6'b010001) begin
         bad++; $display("FAIL flush_idle_data got=%b want=010001", st);
      end
      cyc(); clear_inputs();
   endtask

   task automatic test_flush_fetch();
      cyc(); inst_req = 1'b1; inst_addr = 32'h1C000030;
      cyc(); inst_req = 1'b0; bus_addr_ok = 1'b1;
      cyc(); bus_addr_ok = 1'b0; flush = 1'b1;
      cyc(); flush = 1'b0; bus_data_ok = 1'b1; bus_rdata = 32'hCAFEF00D; #1;
      total++;
      if (st !== 6'b000001) begin
         bad++; $display("FAIL flush_fetch_suppressed got=%b want=000001", st);
      end
      cyc(); bus_data_ok = 1'b0; #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL flush_fetch_idle got=%b want=000000", st);
      end
   endtask

   task automatic test_flush_store();
      cyc(); data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'hF; data_addr = 32'h00000200;
      data_wdata = 32'h12345678;
      cyc(); data_req = 1'b0; flush = 1'b1; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b001011 || bus_wdata !== 32'h12345678) begin
         bad++; $display("FAIL flush_store_addr got=%b wdata=%h want=001011", st, bus_wdata);
      end
      cyc(); bus_addr_ok = 1'b0;
      cyc(); bus_data_ok = 1'b1; #1;
      total++;
      if (st !== 6'b000101) begin
         bad++; $display("FAIL flush_store_done got=%b want=000101", st);
      end
      cyc(); clear_inputs();
   endtask

   task automatic test_reset_mid();
      cyc(); data_req = 1'b1; data_addr = 32'h00000300;
      cyc(); data_req = 1'b0; bus_addr_ok = 1'b1;
      cyc(); bus_addr_ok = 1'b0; reset = 1'b1; #1;
      total++;
      if (st !== 6'b000000 || bus_addr !== 32'd0) begin
         bad++; $display("FAIL reset_mid_async got=%b addr=%h want=000000", st, bus_addr);
      end
      cyc(); reset = 1'b0; bus_data_ok = 1'b1; #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL reset_mid_no_ok got=%b want=000000", st);
      end
      cyc(); bus_data_ok = 1'b0; #1;
      total++;
      if (st !== 6'b000000) begin
         bad++; $display("FAIL reset_mid_quiet got=%b want=000000", st);
      end
      data_req = 1'b1; data_addr = 32'h00000304;
      cyc(); data_req = 1'b0; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b001011 || bus_addr !== 32'h00000304) begin
         bad++; $display("FAIL reset_mid_new_req got=%b addr=%h want=001011", st, bus_addr);
      end
      cyc(); bus_addr_ok = 1'b0;
      cyc(); bus_data_ok = 1'b1;
      cyc(); clear_inputs();
   endtask

   task automatic test_addr_stall();
      cyc(); inst_req = 1'b1; inst_addr = 32'h1C000040; inst_size = 2'd2;
      for (int i = 0; i < 5; i++) begin
         cyc();
         inst_addr = 32'hA0000000 + i; inst_wr = i[0]; data_req = 1'b1;
         data_addr = 32'hB0000000 + i; data_wr = 1'b1;
         #1;
         total++;
         if (st !== 6'b000011 || bus_addr !== 32'h1C000040 || bus_wr !== 1'b0 || bus_size !== 2'd2) begin
            bad++; $display("FAIL addr_stall_%0d got=%b addr=%h wr=%b want=000011 addr=1c000040 wr=0",
                            i, st, bus_addr, bus_wr);
         end
      end
      cyc(); inst_req = 1'b0; data_req = 1'b0; bus_addr_ok = 1'b1; #1;
      total++;
      if (st !== 6'b100011 || bus_addr !== 32'h1C000040) begin
         bad++; $display("FAIL addr_stall_accept got=%b addr=%h want=100011", st, bus_addr);
      end
      cyc(); bus_addr_ok = 1'b0;
      cyc(); bus_data_ok = 1'b1; #1;
      total++;
      if (st !== 6'b010001) begin
         bad++; $display("FAIL addr_stall_done got=%b want=010001", st);
      end
      cyc(); clear_inputs();
   endtask

   initial begin
      test_reset();
      test_inst_read();
      test_priority();
      test_flush_idle();
      test_flush_fetch();
      test_flush_store();
      test_reset_mid();
      test_addr_stall();
      cyc();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
